keyboard_decoder: RTL

KEYBOARD_DECODER -- requirements
Module: keyboard_decoder

---
 rtl/kbd_pkg.sv | 30 +++
 rtl/kbd_modifiers.sv | 56 +++++
 rtl/keyboard_decoder.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/kbd_pkg.sv
// Shared constants and types for the PS/2 set-2 keyboard decoder.
// Holds scancode constants, the decoder FSM state encoding and the
// keymap ROM address layout.
package kbd_pkg;

    localparam int unsigned CODE_W = 8;
    localparam int unsigned ADDR_W = 11;

    localparam logic [CODE_W-1:0] SC_EXT    = 8'hE0;
    localparam logic [CODE_W-1:0] SC_BRK    = 8'hF0;
    localparam logic [CODE_W-1:0] SC_LSHIFT = 8'h12;
    localparam logic [CODE_W-1:0] SC_RSHIFT = 8'h59;
    localparam logic [CODE_W-1:0] SC_CAPS   = 8'h58;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOOKUP = 2'd1,
        ST_FETCH  = 2'd2,
        ST_OUTPUT = 2'd3
    } state_t;

    // Keymap address: one 256-entry plane per {ext, caps, shift} combination.
    typedef struct packed {
        logic              ext;
        logic              caps;
        logic              shift;
        logic [CODE_W-1:0] code;
    } rom_addr_t;

endpackage

// File: rtl/kbd_modifiers.sv
// Shift / caps-lock tracking for the keyboard decoder.
// Ports:
//   clk, reset  - clock, synchronous active-high reset
//   update      - strobe: apply code as a make or break event
//   is_break    - 1 when the event is a key release
//   code        - set-2 scancode of the event
//   shift_c     - either shift key currently held (combinational OR)
//   caps        - caps-lock state (registered)
module kbd_modifiers
    import kbd_pkg::*;
#(
    parameter logic CAPS_INIT = 1'b0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              update,
    input  logic              is_break,
    input  logic [CODE_W-1:0] code,
    output logic              shift_c,
    output logic              caps
);

    logic shift_l;
    logic shift_r;
    logic caps_held;

    // Held bits per modifier; caps toggles only on the first make so
    // typematic repeats of the caps key are ignored.
    always_ff @(posedge clk) begin
        if (reset) begin
            shift_l   <= 1'b0;
            shift_r   <= 1'b0;
            caps_held <= 1'b0;
            caps      <= CAPS_INIT;
        end else if (update) begin
            case (code)
                SC_LSHIFT: shift_l <= ~is_break;
                SC_RSHIFT: shift_r <= ~is_break;
                SC_CAPS: begin
                    if (is_break) begin
                        caps_held <= 1'b0;
                    end else begin
                        if (!caps_held) begin
                            caps <= ~caps;
                        end
                        caps_held <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign shift_c = shift_l | shift_r;

endmodule

// File: rtl/keyboard_decoder.sv
// PS/2 set-2 scancode to ASCII decoder using an external registered keymap ROM.
// Ports:
//   clk, reset        - clock, synchronous active-high reset
//   scancode[7:0]     - byte from the PS/2 receiver, qualified by scancode_valid
//   rom_addr[10:0]    - keymap address {ext, caps, shift, code}
//   rom_dout[7:0]     - keymap data, one cycle after rom_addr
//   char[7:0]         - decoded character, held while char_valid
//   char_valid        - character pending; cleared after char_ready
//   caps_led          - caps-lock state
//   overrun           - one-cycle pulse when a scancode arrives while busy
module keyboard_decoder
    import kbd_pkg::*;
#(
    parameter logic CAPS_INIT = 1'b0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [CODE_W-1:0] scancode,
    input  logic              scancode_valid,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [CODE_W-1:0] rom_dout,
    output logic [CODE_W-1:0] char,
    output logic              char_valid,
    input  logic              char_ready,
    output logic              caps_led,
    output logic              overrun
);

    state_t            state_q, state_d;
    logic              ext_q, ext_d;
    logic              brk_q, brk_d;
    rom_addr_t         addr_q, addr_d;
    logic [CODE_W-1:0] char_q, char_d;
    logic              cv_q, cv_d;
    logic              ovr_d;
    logic              mod_update_c;
    logic              shift_c;
    logic              caps;

    kbd_modifiers #(
        .CAPS_INIT (CAPS_INIT)
    ) u_modifiers (
        .clk      (clk),
        .reset    (reset),
        .update   (mod_update_c),
        .is_break (brk_q),
        .code     (scancode),
        .shift_c  (shift_c),
        .caps     (caps)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d      = state_q;
        ext_d        = ext_q;
        brk_d        = brk_q;
        addr_d       = addr_q;
        char_d       = char_q;
        cv_d         = cv_q;
        mod_update_c = 1'b0;
        // Any strobe outside IDLE is lost; flags are left untouched.
        ovr_d        = scancode_valid && (state_q != ST_IDLE);

        case (state_q)
            ST_IDLE: begin
                if (scancode_valid) begin
                    if (scancode == SC_EXT) begin
                        ext_d = 1'b1;
                    end else if (scancode == SC_BRK) begin
                        brk_d = 1'b1;
                    end else if (brk_q) begin
                        // Key release: update modifiers only, nothing emitted.
                        brk_d        = 1'b0;
                        ext_d        = 1'b0;
                        mod_update_c = 1'b1;
                    end else begin
                        // Address uses modifier state from before this key.
                        addr_d.ext   = ext_q;
                        addr_d.caps  = caps;
                        addr_d.shift = shift_c;
                        addr_d.code  = scancode;
                        ext_d        = 1'b0;
                        mod_update_c = 1'b1;
                        state_d      = ST_LOOKUP;
                    end
                end
            end
            ST_LOOKUP: begin
                state_d = ST_FETCH;
            end
            ST_FETCH: begin
                // A zero entry marks keys with no printable character.
                if (rom_dout != 8'h00) begin
                    char_d  = rom_dout;
                    cv_d    = 1'b1;
                    state_d = ST_OUTPUT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_OUTPUT: begin
                if (char_ready) begin
                    cv_d    = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Datapath and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            ext_q   <= 1'b0;
            brk_q   <= 1'b0;
            addr_q  <= '0;
            char_q  <= '0;
            cv_q    <= 1'b0;
            overrun <= 1'b0;
        end else begin
            ext_q   <= ext_d;
            brk_q   <= brk_d;
            addr_q  <= addr_d;
            char_q  <= char_d;
            cv_q    <= cv_d;
            overrun <= ovr_d;
        end
    end

    assign rom_addr   = addr_q;
    assign char       = char_q;
    assign char_valid = cv_q;
    assign caps_led   = caps;

endmodule
